rep_range_sum: RTL and testbench

//  Sequential engine summing every number in [lb_in, ub_in] that has exactly num_digits digits
//  and consists of one pat_len-digit pattern repeated num_digits/pat_len times.

---
 rtl/rep_range_sum_if.sv | 44 ++++
 rtl/rep_range_sum.sv | 236 +++++++++++++++++++++++
 tb/tb_rep_range_sum.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rep_range_sum_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rep_range_sum_if                                                           |
// | Request/result bundle for rep_range_sum. The REP_SUM_CNT_EN macro adds     |
// | the cnt_out signal to the bundle.                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface rep_range_sum_if #(
  parameter int DATA_W     = 64,
  parameter int MAX_DIGITS = 18
);
  localparam int DW = $clog2(MAX_DIGITS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     lb_in;
  logic [DATA_W-1:0]     ub_in;
  logic [DW-1:0]         num_digits;
  logic [DW-1:0]         pat_len;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   sum_out;
  logic                  err_out;
`ifdef REP_SUM_CNT_EN
  logic [DATA_W-1:0]     cnt_out;
`endif

  modport master (
    output in_valid, lb_in, ub_in, num_digits, pat_len, out_ready,
`ifdef REP_SUM_CNT_EN
    input  cnt_out,
`endif
    input  in_ready, out_valid, sum_out, err_out
  );

  modport slave (
    input  in_valid, lb_in, ub_in, num_digits, pat_len, out_ready,
`ifdef REP_SUM_CNT_EN
    output cnt_out,
`endif
    output in_ready, out_valid, sum_out, err_out
  );
endinterface
`default_nettype wire

// File: rtl/rep_range_sum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rep_range_sum                                                              |
// | Sums all L-digit numbers in [lb,ub] made of one p-digit pattern repeated.  |
// | Optional feature macro: REP_SUM_CNT_EN (adds the match count output).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rep_range_sum #(
  parameter int DATA_W     = 64,
  parameter int MAX_DIGITS = 18
) (
  input  wire logic           clock,
  input  wire logic           reset,
  rep_range_sum_if.slave      bus
);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int CW = $clog2(DATA_W);
  localparam int PW = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUILD  = 3'd1,
    S_DIV_LO = 3'd2,
    S_DIV_HI = 3'd3,
    S_CALC   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   lb_q, lb_d;
  logic [DATA_W-1:0]   ub_q, ub_d;
  logic [DW-1:0]       len_q, len_d;
  logic [DW-1:0]       pat_q, pat_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [DATA_W-1:0]   rep_q, rep_d;
  logic [DATA_W-1:0]   pow_p_q, pow_p_d;
  logic [DATA_W-1:0]   pow_pm1_q, pow_pm1_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [CW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   qlo_q, qlo_d;
  logic [DATA_W-1:0]   qhi_q, qhi_d;
  logic [PW-1:0]       sum_q, sum_d;
  logic                err_q, err_d;
`ifdef REP_SUM_CNT_EN
  logic [DATA_W-1:0]   cnt_q, cnt_d;
`endif

  function automatic logic [DATA_W-1:0] pow10(input logic [DW-1:0] e);
    logic [DATA_W-1:0] v;
    v = DATA_W'(1);
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (DW'(i) < e) v = v * DATA_W'(10);
    end
    return v;
  endfunction

  // Request legality; the modulo divisor is forced nonzero so p=0 never divides by zero.
  logic [DW-1:0] w_safe_p;
  logic          w_legal;
  assign w_safe_p = (bus.pat_len == '0) ? DW'(1) : bus.pat_len;
  assign w_legal  = (bus.pat_len != '0) && (bus.pat_len < bus.num_digits) &&
                    (bus.num_digits <= DW'(MAX_DIGITS)) &&
                    ((bus.num_digits % w_safe_p) == '0);

  // One restoring-divide step, shared by the lower and upper bound divisions.
  logic [DATA_W:0]     w_rem_sh;
  logic                w_ge;
  logic [DATA_W-1:0]   w_rem_nx;
  logic [DATA_W-1:0]   w_quo_nx;
  logic                w_div_last;
  assign w_rem_sh   = {rem_q, dvd_q[DATA_W-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, rep_q});
  assign w_rem_nx   = w_ge ? DATA_W'(w_rem_sh - {1'b0, rep_q}) : w_rem_sh[DATA_W-1:0];
  assign w_quo_nx   = {quo_q[DATA_W-2:0], w_ge};
  assign w_div_last = (bit_q == CW'(DATA_W - 1));

  // Clamp the quotient window to genuine p-digit patterns, then sum the arithmetic series.
  logic [DATA_W-1:0]   w_lo, w_hi, w_hi_cap, w_span;
  logic                w_nonempty;
  logic [PW-1:0]       w_pair, w_prod, w_sum;
  assign w_hi_cap   = pow_p_q - DATA_W'(1);
  assign w_lo       = (qlo_q > pow_pm1_q) ? qlo_q : pow_pm1_q;
  assign w_hi       = (qhi_q < w_hi_cap) ? qhi_q : w_hi_cap;
  assign w_nonempty = (w_hi >= w_lo);
  assign w_span     = w_hi - w_lo + DATA_W'(1);
  assign w_pair     = PW'(w_lo) + PW'(w_hi);
  assign w_prod     = w_pair * PW'(w_span);
  assign w_sum      = (w_prod >> 1) * PW'(rep_q);

  always_comb begin
    state_d   = state_q;
    lb_d      = lb_q;
    ub_d      = ub_q;
    len_d     = len_q;
    pat_d     = pat_q;
    dig_d     = dig_q;
    rep_d     = rep_q;
    pow_p_d   = pow_p_q;
    pow_pm1_d = pow_pm1_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    bit_d     = bit_q;
    qlo_d     = qlo_q;
    qhi_d     = qhi_q;
    sum_d     = sum_q;
    err_d     = err_q;
`ifdef REP_SUM_CNT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          lb_d      = bus.lb_in;
          ub_d      = bus.ub_in;
          len_d     = bus.num_digits;
          pat_d     = bus.pat_len;
          dig_d     = '0;
          rep_d     = '0;
          pow_p_d   = pow10(bus.pat_len);
          pow_pm1_d = pow10(bus.pat_len - DW'(1));
          if (w_legal) begin
            state_d = S_BUILD;
          end else begin
            state_d = S_DONE;
            sum_d   = '0;
            err_d   = 1'b1;
`ifdef REP_SUM_CNT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_BUILD: begin
        rep_d = rep_q * pow_p_q + DATA_W'(1);
        dig_d = dig_q + pat_q;
        if (dig_d == len_q) begin
          state_d = S_DIV_LO;
          dvd_d   = lb_q + rep_d - DATA_W'(1);
          rem_d   = '0;
          quo_d   = '0;
          bit_d   = '0;
        end
      end
      S_DIV_LO, S_DIV_HI: begin
        rem_d = w_rem_nx;
        quo_d = w_quo_nx;
        dvd_d = dvd_q << 1;
        bit_d = bit_q + CW'(1);
        if (w_div_last) begin
          if (state_q == S_DIV_LO) begin
            state_d = S_DIV_HI;
            qlo_d   = w_quo_nx;
            dvd_d   = ub_q;
            rem_d   = '0;
            quo_d   = '0;
            bit_d   = '0;
          end else begin
            state_d = S_CALC;
            qhi_d   = w_quo_nx;
          end
        end
      end
      S_CALC: begin
        state_d = S_DONE;
        sum_d   = w_nonempty ? w_sum : '0;
        err_d   = 1'b0;
`ifdef REP_SUM_CNT_EN
        cnt_d   = w_nonempty ? w_span : '0;
`endif
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lb_q      <= '0;
      ub_q      <= '0;
      len_q     <= '0;
      pat_q     <= '0;
      dig_q     <= '0;
      rep_q     <= '0;
      pow_p_q   <= '0;
      pow_pm1_q <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      bit_q     <= '0;
      qlo_q     <= '0;
      qhi_q     <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
`ifdef REP_SUM_CNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lb_q      <= lb_d;
      ub_q      <= ub_d;
      len_q     <= len_d;
      pat_q     <= pat_d;
      dig_q     <= dig_d;
      rep_q     <= rep_d;
      pow_p_q   <= pow_p_d;
      pow_pm1_q <= pow_pm1_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      bit_q     <= bit_d;
      qlo_q     <= qlo_d;
      qhi_q     <= qhi_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
`ifdef REP_SUM_CNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum_out   = sum_q;
  assign bus.err_out   = err_q;
`ifdef REP_SUM_CNT_EN
  assign bus.cnt_out   = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rep_range_sum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rep_range_sum                                                           |
// | Directed self-checking bench for rep_range_sum.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rep_range_sum;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  rep_range_sum_if #(.DATA_W(64), .MAX_DIGITS(18)) bus ();

  rep_range_sum #(.DATA_W(64), .MAX_DIGITS(18)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request, measure the cycle at which out_valid appears, check results.
  task automatic run_req(input string tag, input logic [63:0] lb, input logic [63:0] ub,
                         input logic [4:0] l, input logic [4:0] p, input int exp_cyc,
                         input logic [127:0] exp_sum, input logic exp_err,
                         input logic [63:0] exp_cnt, input bit hold);
    int cyc;
    logic [127:0] held_sum;
    $display("request %s: expect sum %0d count %0d", tag, exp_sum, exp_cnt);
    check({tag, ".ready_before"}, 128'(bus.in_ready), 128'd1);
    bus.out_ready  = !hold;
    bus.lb_in      = lb;
    bus.ub_in      = ub;
    bus.num_digits = l;
    bus.pat_len    = p;
    bus.in_valid   = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, ".latency"}, 128'(cyc), 128'(exp_cyc));
    check({tag, ".sum"}, bus.sum_out, exp_sum);
    check({tag, ".err"}, 128'(bus.err_out), 128'(exp_err));
`ifdef REP_SUM_CNT_EN
    check({tag, ".cnt"}, 128'(bus.cnt_out), 128'(exp_cnt));
`endif
    check({tag, ".ready_busy"}, 128'(bus.in_ready), 128'd0);
    if (hold) begin
      held_sum = bus.sum_out;
      for (int k = 0; k < 5; k++) begin
        @(posedge clock); #1;
        check({tag, ".hold_valid"}, 128'(bus.out_valid), 128'd1);
        check({tag, ".hold_sum"}, bus.sum_out, held_sum);
        check({tag, ".hold_ready"}, 128'(bus.in_ready), 128'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clock); #1;
    check({tag, ".valid_after"}, 128'(bus.out_valid), 128'd0);
    check({tag, ".ready_after"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    int seen;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.lb_in      = '0;
    bus.ub_in      = '0;
    bus.num_digits = '0;
    bus.pat_len    = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("reset.in_ready", 128'(bus.in_ready), 128'd1);
    check("reset.out_valid", 128'(bus.out_valid), 128'd0);
    check("reset.sum", bus.sum_out, 128'd0);
    check("reset.err", 128'(bus.err_out), 128'd0);
`ifdef REP_SUM_CNT_EN
    check("reset.cnt", 128'(bus.cnt_out), 128'd0);
`endif

    run_req("c1_L2p1", 64'd11, 64'd22, 5'd2, 5'd1, 132, 128'd33, 1'b0, 64'd2, 1'b0);
    run_req("c2_L6p3", 64'd123000, 64'd999999, 5'd6, 5'd3, 132, 128'd492488997, 1'b0, 64'd877, 1'b0);
    run_req("c3_empty", 64'd100000, 64'd100000, 5'd6, 5'd2, 133, 128'd0, 1'b0, 64'd0, 1'b0);
    run_req("c4_L5p2", 64'd0, 64'd99999, 5'd5, 5'd2, 1, 128'd0, 1'b1, 64'd0, 1'b0);
    run_req("c4_p0", 64'd0, 64'd99999, 5'd5, 5'd0, 1, 128'd0, 1'b1, 64'd0, 1'b0);
    run_req("c4_pL", 64'd0, 64'd99999, 5'd5, 5'd5, 1, 128'd0, 1'b1, 64'd0, 1'b0);
    run_req("c4_Lbig", 64'd0, 64'd99999, 5'd19, 5'd1, 1, 128'd0, 1'b1, 64'd0, 1'b0);
    run_req("L4p2_full", 64'd1000, 64'd9999, 5'd4, 5'd2, 132, 128'd495405, 1'b0, 64'd90, 1'b0);
    run_req("lb_gt_ub", 64'd50, 64'd20, 5'd2, 5'd1, 132, 128'd0, 1'b0, 64'd0, 1'b0);
    run_req("L18p9", 64'd0, 64'd999999999999999999, 5'd18, 5'd9, 132,
            128'd495000000044999999550000000, 1'b0, 64'd900000000, 1'b0);
    run_req("L18p1", 64'd0, 64'd999999999999999999, 5'd18, 5'd1, 148,
            128'd4999999999999999995, 1'b0, 64'd9, 1'b0);
    run_req("c5_hold", 64'd11, 64'd22, 5'd2, 5'd1, 132, 128'd33, 1'b0, 64'd2, 1'b1);

    // Abort a request mid-division with reset.
    bus.lb_in      = 64'd11;
    bus.ub_in      = 64'd22;
    bus.num_digits = 5'd2;
    bus.pat_len    = 5'd1;
    bus.in_valid   = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
    end
    check("c6.busy", 128'(bus.in_ready), 128'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("c6.ready_after_reset", 128'(bus.in_ready), 128'd1);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.out_valid) seen++;
      @(posedge clock); #1;
    end
    check("c6.no_result", 128'(seen), 128'd0);
    run_req("c6_follow", 64'd123000, 64'd999999, 5'd6, 5'd3, 132, 128'd492488997, 1'b0, 64'd877, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
